mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- AW, 10, word address width (1024-word unified memory)
- DW, 32, data width
- STARVE_MAX, 3, consecutive fetch denials that force a fetch grant
REQ-002 The block SHALL have these ports (clock and reset first):
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- halt  in  1  pipeline halted; blocks new fetch grants
- if_req  in  1  instruction fetch request, held until granted
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch granted this cycle
- if_valid  out  1  fetch data valid
- if_rdata  out  DW  fetch data
- dm_req  in  1  data access request, held until granted
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data word address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  data access granted this cycle
- dm_valid  out  1  load data valid / store acknowledge
- dm_rdata  out  DW  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en

Function
REQ-003 At most one of if_gnt and dm_gnt SHALL be high in any cycle; each grant is combinational from the requests and the registered arbiter state.
REQ-004 Arbitration SHALL follow this priority:
- dm_req alone -> dm_gnt
- if_req alone with halt=0 -> if_gnt
- both with halt=0 -> dm_gnt, unless starve_cnt == STARVE_MAX, then if_gnt
REQ-005 When halt=1, if_gnt SHALL be 0 regardless of if_req; data requests SHALL still be served so in-flight stores drain.
REQ-006 In a granted cycle, mem_en SHALL be 1 and mem_addr SHALL be the winner's address. mem_we SHALL equal dm_we on a data grant and 0 on a fetch grant. mem_wdata SHALL equal dm_wdata on a data grant and 0 otherwise.
REQ-007 With no grant, mem_en, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-008 The block SHALL hold registered state owner in {IDLE, FETCH, DATA}, loaded each cycle with the current winner (IDLE if no grant).
REQ-009 Latency for all accesses SHALL be exactly 1 cycle: a grant in cycle N gives a one-cycle valid pulse in cycle N+1.
- owner==FETCH in N+1 -> if_valid=1, if_rdata=mem_rdata
- owner==DATA in N+1 -> dm_valid=1, dm_rdata=mem_rdata (ignored on stores)
REQ-010 When its valid is low, if_rdata/dm_rdata SHALL be 0.
REQ-011 Back-to-back grants SHALL be supported: a new grant may issue in the same cycle that the previous access's valid is returned.
REQ-012 starve_cnt (width clog2(STARVE_MAX+1)) SHALL update each cycle as follows:
- reset to 0 on any if_gnt
- reset to 0 when if_req=0 or halt=1
- incremented, saturating at STARVE_MAX, when if_req=1, halt=0 and dm_gnt=1
REQ-013 A requester whose request drops before grant SHALL simply not be served; the block SHALL keep no queued request.
REQ-014 Asserting halt in the cycle after a fetch grant SHALL NOT suppress that fetch's if_valid.

Reset
REQ-015 While rst=1, the block SHALL force owner=IDLE, starve_cnt=0, and if_valid=dm_valid=0; with no requests, all other outputs are 0 per REQ-007/REQ-010.
REQ-016 Reset asserted mid-access SHALL drop the pending valid pulse; the first grant after rst deasserts SHALL be decided on the clk edge following deassertion, using reset-state arbitration.

Verification
REQ-017 Fetch only: if_req=1, if_addr=5, memory word 5 = 0x2800000A -> if_gnt=1 with mem_addr=5, mem_we=0; next cycle if_valid=1, if_rdata=0x2800000A.
REQ-018 Store then load: dm_req=1, dm_we=1, dm_addr=20, dm_wdata=0xDEADBEEF, then a load from 20 -> mem_we=1 on the first grant; dm_valid pulses after each access; the load returns dm_rdata=0xDEADBEEF.
REQ-019 Starvation with STARVE_MAX=3: if_req and dm_req held high continuously -> dm_gnt for 3 cycles, if_gnt on the 4th, then repeating 3:1.
REQ-020 Halt: halt=1 with if_req=1 and dm_req=1 -> only dm_gnt, if_gnt never asserts, starve_cnt stays 0; halt=0 -> if_gnt resumes per REQ-004.
REQ-021 Back-to-back fetches: addresses 0,1,2 presented on consecutive cycles -> if_valid high for 3 consecutive cycles with words 0,1,2 in order.
REQ-022 Reset mid-op: rst pulsed in the cycle after a dm_gnt -> dm_valid stays 0, outputs return to reset values, and normal grants resume after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX denials.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} owner_t;

    owner_t          owner_q, owner_d;
    logic [SW-1:0]   starve_q, starve_d;

    // Grants are suppressed while reset is held so the first decision
    // after release uses the reset-state counter.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!rst) begin
            if (dm_req && if_req && !halt) begin
                if (starve_q == SW'(STARVE_MAX)) if_gnt = 1'b1;
                else                             dm_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end else if (if_req && !halt) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    always_comb begin
        owner_d = IDLE;
        if (if_gnt)      owner_d = FETCH;
        else if (dm_gnt) owner_d = DATA;
    end

    always_comb begin
        starve_d = starve_q;
        if (if_gnt || !if_req || halt) begin
            starve_d = '0;
        end else if (dm_gnt && starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= IDLE;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Read data is steered by who owned the port last cycle and zeroed otherwise.
    assign if_valid = (owner_q == FETCH);
    assign dm_valid = (owner_q == DATA);
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign dm_rdata = dm_valid ? mem_rdata : '0;

endmodule
